// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. Divides clk down to a pixel
//   tick, runs the horizontal/vertical raster counters, and produces
//   syncs, display enable, line/frame strobes, NES-space coordinates and a
//   line-fetch request one line ahead of display.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           run enable; low freezes divider, counters and syncs
//   pix_en       pixel tick, one clk wide
//   h_count      horizontal position 0..H_TOTAL-1
//   v_count      vertical position 0..V_TOTAL-1
//   h_sync       horizontal sync (polarity per SYNC_ACTIVE_HIGH)
//   v_sync       vertical sync (polarity per SYNC_ACTIVE_HIGH)
//   video_on     inside the visible area
//   line_start   first pixel tick of each line
//   frame_start  first pixel tick of each frame
//   nes_x        h_count >> SCALE_SHIFT
//   nes_y        v_count >> SCALE_SHIFT
//   fetch_req    one-clk request to fill the line buffer for fetch_row
//   fetch_row    NES row to fetch, held until the next request

module vga_timing_gen #(
    parameter int CLK_DIV          = 4,
    parameter int CW               = 10,
    parameter int H_DISPLAY        = 512,
    parameter int H_FRONT          = 80,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 112,
    parameter int V_DISPLAY        = 480,
    parameter int V_FRONT          = 24,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 24,
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int SCALE_SHIFT      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] nes_x,
    output logic [CW-1:0] nes_y,
    output logic          fetch_req,
    output logic [CW-1:0] fetch_row
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_STOP  = CW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_STOP  = CW'(V_DISPLAY + V_FRONT + V_SYNC);
    // Low SCALE_SHIFT bits of a row; all-zero marks the first display line
    // of each NES row. With SCALE_SHIFT=0 the mask is empty and every line
    // qualifies.
    localparam logic [CW-1:0] ROW_MASK = CW'((1 << SCALE_SHIFT) - 1);
    localparam logic          SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);

    logic [DW-1:0] div_cnt;
    logic          h_last;
    logic          v_last;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic [CW-1:0] nv;
    logic          fetch_hit;

    // ---------------- pixel divider ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    // rst is included so that CLK_DIV=1 (div_cnt stuck at 0) still shows no
    // tick while reset is held.
    assign pix_en = en && !rst && (div_cnt == DIV_LAST);

    // ---------------- next-count decode ----------------
    always_comb begin
        h_last = (h_count == H_LAST);
        v_last = (v_count == V_LAST);
        nv     = v_last ? '0 : v_count + CW'(1);
        h_next = h_last ? '0 : h_count + CW'(1);
        v_next = h_last ? nv : v_count;
    end

    // ---------------- counters and syncs ----------------
    // Syncs are decoded from the next counts so they change on the same
    // edge as h_count/v_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
            h_sync  <= ~SYNC_ON;
            v_sync  <= ~SYNC_ON;
        end else if (pix_en) begin
            h_count <= h_next;
            v_count <= v_next;
            h_sync  <= (h_next >= HS_START && h_next < HS_STOP) ? SYNC_ON : ~SYNC_ON;
            v_sync  <= (v_next >= VS_START && v_next < VS_STOP) ? SYNC_ON : ~SYNC_ON;
        end
    end

    // ---------------- combinational outputs ----------------
    assign video_on    = (h_count < H_VIS) && (v_count < V_VIS);
    assign line_start  = pix_en && (h_count == '0);
    assign frame_start = line_start && (v_count == '0);
    assign nes_x       = h_count >> SCALE_SHIFT;
    assign nes_y       = v_count >> SCALE_SHIFT;

    // ---------------- line fetch ----------------
    // Requested on the last tick of the preceding line, so the buffer for
    // row 0 is requested at the end of line V_TOTAL-1.
    assign fetch_hit = pix_en && h_last && (nv < V_VIS) && ((nv & ROW_MASK) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_req <= 1'b0;
            fetch_row <= '0;
        end else begin
            fetch_req <= fetch_hit;
            if (fetch_hit) begin
                fetch_row <= nv >> SCALE_SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Small raster so several complete frames fit in a short run.
    localparam int HD = 10, HF = 3, HS = 4, HB = 5;
    localparam int VD = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int CW = 6;

    typedef struct {
        int div;
        int ss;
        int ah;
    } cfg_t;

    typedef struct {
        logic [31:0] pix_en, h, v, hs, vs, von, ls, fs, nx, ny, fr, frow;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    logic          a_pix_en, a_h_sync, a_v_sync, a_video_on, a_line_start, a_frame_start, a_fetch_req;
    logic [CW-1:0] a_h_count, a_v_count, a_nes_x, a_nes_y, a_fetch_row;
    logic          b_pix_en, b_h_sync, b_v_sync, b_video_on, b_line_start, b_frame_start, b_fetch_req;
    logic [CW-1:0] b_h_count, b_v_count, b_nes_x, b_nes_y, b_fetch_row;

    vga_timing_gen #(
        .CLK_DIV(3), .CW(CW),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_HIGH(1), .SCALE_SHIFT(1)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .pix_en(a_pix_en), .h_count(a_h_count), .v_count(a_v_count),
        .h_sync(a_h_sync), .v_sync(a_v_sync), .video_on(a_video_on),
        .line_start(a_line_start), .frame_start(a_frame_start),
        .nes_x(a_nes_x), .nes_y(a_nes_y),
        .fetch_req(a_fetch_req), .fetch_row(a_fetch_row)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .CW(CW),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_HIGH(0), .SCALE_SHIFT(0)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .pix_en(b_pix_en), .h_count(b_h_count), .v_count(b_v_count),
        .h_sync(b_h_sync), .v_sync(b_v_sync), .video_on(b_video_on),
        .line_start(b_line_start), .frame_start(b_frame_start),
        .nes_x(b_nes_x), .nes_y(b_nes_y),
        .fetch_req(b_fetch_req), .fetch_row(b_fetch_row)
    );

    int   vecs = 0;
    int   errs = 0;
    cfg_t cfg_a, cfg_b;

    // Reference state: enabled clocks since reset release, plus the fetch
    // pulse/row the DUT should be showing.
    int   n_a, n_b, row_a, row_b;
    logic ff_a, ff_b;

    // Raster position is simply (enabled clocks / divider) laid out row-major
    // over an HT x VT frame.
    function automatic obs_t model(cfg_t c, int n, logic en_v, logic rst_v, logic ff, int row);
        obs_t e;
        int   p, h, v;
        logic pe, hs_on, vs_on;
        if (rst_v) begin
            h  = 0;
            v  = 0;
            pe = 1'b0;
        end else begin
            p  = n / c.div;
            h  = p % HT;
            v  = (p / HT) % VT;
            pe = en_v && ((n % c.div) == c.div - 1);
        end
        hs_on    = (h >= HD + HF) && (h < HD + HF + HS);
        vs_on    = (v >= VD + VF) && (v < VD + VF + VS);
        e.pix_en = 32'(pe);
        e.h      = 32'(h);
        e.v      = 32'(v);
        e.hs     = 32'((c.ah != 0) ? hs_on : !hs_on);
        e.vs     = 32'((c.ah != 0) ? vs_on : !vs_on);
        e.von    = 32'((h < HD) && (v < VD));
        e.ls     = 32'(pe && h == 0);
        e.fs     = 32'(pe && h == 0 && v == 0);
        e.nx     = 32'(h >> c.ss);
        e.ny     = 32'(v >> c.ss);
        e.fr     = 32'(ff);
        e.frow   = 32'(row);
        return e;
    endfunction

    task automatic advance(cfg_t c, logic en_v, inout int n, inout logic ff, inout int row);
        int   p, h, v, nv;
        logic pe, hit;
        p   = n / c.div;
        h   = p % HT;
        v   = (p / HT) % VT;
        pe  = en_v && ((n % c.div) == c.div - 1);
        nv  = (v + 1) % VT;
        hit = pe && (h == HT - 1) && (nv < VD) && ((nv % (1 << c.ss)) == 0);
        ff  = hit;
        if (hit) row = nv >> c.ss;
        if (en_v) n++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare(string name, obs_t o, obs_t e);
        chk({name, ".pix_en"},      o.pix_en, e.pix_en);
        chk({name, ".h_count"},     o.h,      e.h);
        chk({name, ".v_count"},     o.v,      e.v);
        chk({name, ".h_sync"},      o.hs,     e.hs);
        chk({name, ".v_sync"},      o.vs,     e.vs);
        chk({name, ".video_on"},    o.von,    e.von);
        chk({name, ".line_start"},  o.ls,     e.ls);
        chk({name, ".frame_start"}, o.fs,     e.fs);
        chk({name, ".nes_x"},       o.nx,     e.nx);
        chk({name, ".nes_y"},       o.ny,     e.ny);
        chk({name, ".fetch_req"},   o.fr,     e.fr);
        chk({name, ".fetch_row"},   o.frow,   e.frow);
    endtask

    // Called 1 time unit after a rising edge; applies inputs, checks at the
    // falling edge, then advances the model across the next rising edge.
    task automatic step(logic en_v, logic rst_v);
        obs_t oa, ob;
        en  = en_v;
        rst = rst_v;
        if (rst_v) begin
            n_a = 0; n_b = 0; ff_a = 1'b0; ff_b = 1'b0; row_a = 0; row_b = 0;
        end
        @(negedge clk);
        oa.pix_en = 32'(a_pix_en);  oa.h  = 32'(a_h_count);  oa.v  = 32'(a_v_count);
        oa.hs     = 32'(a_h_sync);  oa.vs = 32'(a_v_sync);   oa.von = 32'(a_video_on);
        oa.ls     = 32'(a_line_start); oa.fs = 32'(a_frame_start);
        oa.nx     = 32'(a_nes_x);   oa.ny = 32'(a_nes_y);
        oa.fr     = 32'(a_fetch_req); oa.frow = 32'(a_fetch_row);
        ob.pix_en = 32'(b_pix_en);  ob.h  = 32'(b_h_count);  ob.v  = 32'(b_v_count);
        ob.hs     = 32'(b_h_sync);  ob.vs = 32'(b_v_sync);   ob.von = 32'(b_video_on);
        ob.ls     = 32'(b_line_start); ob.fs = 32'(b_frame_start);
        ob.nx     = 32'(b_nes_x);   ob.ny = 32'(b_nes_y);
        ob.fr     = 32'(b_fetch_req); ob.frow = 32'(b_fetch_row);
        compare("a", oa, model(cfg_a, n_a, en_v, rst_v, ff_a, row_a));
        compare("b", ob, model(cfg_b, n_b, en_v, rst_v, ff_b, row_b));
        if (!rst_v) begin
            advance(cfg_a, en_v, n_a, ff_a, row_a);
            advance(cfg_b, en_v, n_b, ff_b, row_b);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cfg_a.div = 3; cfg_a.ss = 1; cfg_a.ah = 1;
        cfg_b.div = 1; cfg_b.ss = 0; cfg_b.ah = 0;
        n_a = 0; n_b = 0; ff_a = 1'b0; ff_b = 1'b0; row_a = 0; row_b = 0;
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;

        // reset state, including en high while still in reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // free-running: over one frame of dut_a and several of dut_b
        for (int i = 0; i < 1200; i++) step(1'b1, 1'b0);

        // freeze for 50 clocks, then resume
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);

        // random enable pattern
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 9) != 0, 1'b0);

        // mid-frame reset, then restart from (0,0)
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 1000; i++) step($urandom_range(0, 4) != 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 512x480 controller.
- Produces the pixel-enable tick, raster counters, programmable-polarity syncs, display-enable, frame/line strobes and scaled NES-space coordinates.
- Issues a line-fetch request one line ahead, so the PPU line buffer can be filled before the line is displayed.
- Sits between the system clock domain and the VGA pins / PPU line buffer.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1).
- CW, 10, counter width.
- H_DISPLAY, 512, visible pixels per line.
- H_FRONT, 80, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BACK, 112, horizontal back porch.
- V_DISPLAY, 480, visible lines.
- V_FRONT, 24, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BACK, 24, vertical back porch.
- SYNC_ACTIVE_HIGH, 1, sync polarity: 1 = asserted high, 0 = asserted low.
- SCALE_SHIFT, 1, log2 of the display-to-NES pixel scale.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  run enable; low freezes the divider and counters
- pix_en  out  1  pixel tick, one clk wide
- h_count  out  CW  horizontal position, 0..H_TOTAL-1
- v_count  out  CW  vertical position, 0..V_TOTAL-1
- h_sync  out  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
- v_sync  out  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
- video_on  out  1  inside visible area
- line_start  out  1  pulse at first pixel tick of each line
- frame_start  out  1  pulse at first pixel tick of each frame
- nes_x  out  CW  h_count >> SCALE_SHIFT
- nes_y  out  CW  v_count >> SCALE_SHIFT
- fetch_req  out  1  line-fetch request pulse
- fetch_row  out  CW  NES row to fetch, valid while fetch_req is high

Behaviour:
- Totals:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800 at defaults).
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK (530 at defaults).
  - Region order in both axes: display, front porch, sync, back porch.
- Reset (asynchronous, active-high):
  - div_cnt = 0, h_count = 0, v_count = 0.
  - h_sync and v_sync at their deasserted level (0 if SYNC_ACTIVE_HIGH=1, else 1).
  - pix_en, line_start, frame_start, fetch_req = 0.
  - fetch_row = 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en is high and wraps.
  - pix_en = en && div_cnt == CLK_DIV-1.
  - CLK_DIV=1 gives pix_en = en.
  - First pix_en after reset occurs CLK_DIV cycles after release.
- Horizontal counter: advances only on pix_en; wraps H_TOTAL-1 -> 0.
- Vertical counter: advances on pix_en when h_count == H_TOTAL-1; wraps V_TOTAL-1 -> 0. Both wraps on the same tick are legal (frame end).
- Syncs:
  - Registered, updated on the same edge as the counters, decoded from the next counts. Zero skew to h_count/v_count.
  - h_sync is asserted iff H_DISPLAY+H_FRONT <= h_count < H_DISPLAY+H_FRONT+H_SYNC.
  - v_sync uses the same rule on the V parameters.
- video_on: combinational, (h_count < H_DISPLAY) && (v_count < V_DISPLAY).
- Strobes (combinational):
  - line_start = pix_en && h_count == 0.
  - frame_start = line_start && v_count == 0.
  - At reset release both strobes fire on the first pix_en.
- nes_x / nes_y: combinational shifts of the counts. Valid only while video_on is high.
- Line fetch:
  - Let nv = next v_count, i.e. (v_count+1) wrapping V_TOTAL-1 -> 0.
  - fetch_req is a registered pulse, exactly one clk wide, on the clk after the pix_en with h_count == H_TOTAL-1 where:
    - nv < V_DISPLAY, and
    - nv[SCALE_SHIFT-1:0] == 0; with SCALE_SHIFT=0 every visible line qualifies.
  - fetch_row = nv >> SCALE_SHIFT, registered with fetch_req and held until the next request.
  - Defaults: one request per 2 lines, 240 requests per frame. The row-0 request is issued at the end of line V_TOTAL-1.
- en low:
  - All counters and syncs hold.
  - pix_en, line_start, frame_start = 0.
  - A pending fetch_req pulse still completes its single cycle.
- Reset mid-frame: all state returns to the reset values immediately. Counting restarts at (0,0) with frame_start on the first pix_en.
- Widths: CW must hold max(H_TOTAL, V_TOTAL)-1. Counter arithmetic is modulo 2^CW but never reaches overflow.

Test Plan:
- Defaults, run 2 frames:
  - pix_en period is 4 clk.
  - A line is 3200 clk; a frame is 1,696,000 clk.
  - frame_start spacing is 1,696,000 clk; line_start spacing is 3200 clk.
- Defaults, horizontal sync:
  - h_sync is high exactly for h_count 592..687.
  - v_sync is high exactly for v_count 504..505.
  - video_on is low at h_count=512 and high at (511,479).
- SYNC_ACTIVE_HIGH=0, CLK_DIV=1:
  - Syncs are inverted and reset at 1.
  - pix_en is constant 1; a line is 800 clk.
- Fetch at defaults:
  - 240 fetch_req pulses per frame with fetch_row 0..239 in order.
  - First pulse follows the tick at (799,529).
  - No pulse after (799,0); a pulse follows (799,1) with fetch_row = 1.
- en deasserted at (300,100) for 50 clk: counts, syncs and div_cnt freeze, with no pix_en or strobes. Resuming continues from (300,100).
- rst asserted mid-line at (400,250): outputs take their reset values immediately. After release, the first pix_en comes 4 clk later with frame_start=1.
